// File: rtl/enc16to4_seq.sv
// Sequential 16-to-4 priority encoder: serializes set request bits
// lowest index first over a valid/accept handshake. Optional macro: ENC_COUNT_EN adds cnt.
module enc16to4_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        En,
  input  logic        load,
  input  logic [15:0] D,
  output logic        ready,
  output logic        valid,
  output logic [3:0]  W,
  input  logic        accept,
`ifdef ENC_COUNT_EN
  output logic [4:0]  cnt,
`endif
  output logic        done
);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_pend;
  logic [15:0] w_pend_n;
  logic        r_done;
  logic        w_done_n;
  logic [3:0]  w_idx;
  logic        w_valid;
  logic        w_take;

`ifdef ENC_COUNT_EN
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_n;

  function automatic logic [4:0] f_pop(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++)
      n = n + {4'd0, v[i]};
    return n;
  endfunction
`endif

  // Lowest set bit of the pending vector
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (r_pend[i]) w_idx = 4'(i);
  end

  assign w_valid = (r_state == S_SCAN) & En & (|r_pend);
  assign w_take  = w_valid & accept;
  assign ready   = (r_state == S_IDLE);
  assign valid   = w_valid;
  assign W       = w_valid ? w_idx : 4'd0;
  assign done    = r_done;
`ifdef ENC_COUNT_EN
  assign cnt     = r_cnt;
`endif

  // Next-state: capture on load, clear one bit per handshake
  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_done_n  = 1'b0;
`ifdef ENC_COUNT_EN
    w_cnt_n   = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          if (|D) begin
            w_pend_n  = D;
            w_state_n = S_SCAN;
`ifdef ENC_COUNT_EN
            w_cnt_n   = f_pop(D);
`endif
          end else begin
            w_done_n  = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (w_take) begin
          w_pend_n = r_pend & ~(16'd1 << w_idx);
`ifdef ENC_COUNT_EN
          w_cnt_n  = r_cnt - 5'd1;
`endif
          if (w_pend_n == 16'd0) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_pend_n  = '0;
      end
    endcase
  end

  // State, pending vector and done pulse registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_done  <= w_done_n;
    end
  end

`ifdef ENC_COUNT_EN
  // Pending-bit counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= w_cnt_n;
  end
`endif

endmodule

// File: tb/tb_enc16to4_seq.sv
// Testbench for enc16to4_seq: directed vector table, reset
// corner case, and randomized run against a queue-based model.
module tb_enc16to4_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        En;
  logic        load;
  logic [15:0] D;
  logic        ready;
  logic        valid;
  logic [3:0]  W;
  logic        accept;
  logic        done;
`ifdef ENC_COUNT_EN
  logic [4:0]  cnt;
`endif

  int total = 0;
  int bad   = 0;

  enc16to4_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .En     (En),
    .load   (load),
    .D      (D),
    .ready  (ready),
    .valid  (valid),
    .W      (W),
    .accept (accept),
`ifdef ENC_COUNT_EN
    .cnt    (cnt),
`endif
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] d;
    logic        acc;
    logic        rdy;
    logic        vld;
    logic [3:0]  w;
    logic        dn;
  } vec_t;

  vec_t tv[$];

  // model: queue of pending indices, ascending
  int   m_q[$];
  bit   m_busy;
  bit   m_done;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic en, logic ld, logic [15:0] d,
                              logic acc, logic rdy, logic vld,
                              logic [3:0] w, logic dn);
    vec_t v;
    v.en = en; v.ld = ld; v.d = d; v.acc = acc;
    v.rdy = rdy; v.vld = vld; v.w = w; v.dn = dn;
    return v;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy = 0;
    m_done = 0;
  endtask

  // compare outputs with model, then advance model over the edge
  task automatic m_cycle(input string tag);
    bit   e_v;
    int   e_w;
    e_v = m_busy && En && (m_q.size() > 0);
    e_w = e_v ? m_q[0] : 0;
    chk({tag, ".ready"}, ready, !m_busy);
    chk({tag, ".valid"}, valid, e_v);
    chk({tag, ".W"}, W, e_w);
    chk({tag, ".done"}, done, m_done);
`ifdef ENC_COUNT_EN
    chk({tag, ".cnt"}, cnt, m_q.size());
`endif
    m_done = 0;
    if (!m_busy && load) begin
      for (int i = 0; i < 16; i++)
        if (D[i]) m_q.push_back(i);
      if (m_q.size() == 0) m_done = 1;
      else m_busy = 1;
    end else if (e_v && accept) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    En = 1'b1; load = 1'b0; D = '0; accept = 1'b0;
    #2;
    chk("rst.ready", ready, 1);
    chk("rst.valid", valid, 0);
    chk("rst.W", W, 0);
    chk("rst.done", done, 0);
`ifdef ENC_COUNT_EN
    chk("rst.cnt", cnt, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;

    // 8421 drain
    tv.push_back(mk(1,1,16'h8421,1, 1,0,0,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,0,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,5,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,10,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,15,0));
    tv.push_back(mk(1,0,16'h0000,1, 1,0,0,1));
    tv.push_back(mk(1,0,16'h0000,1, 1,0,0,0));
    // zero load
    tv.push_back(mk(1,1,16'h0000,1, 1,0,0,0));
    tv.push_back(mk(1,0,16'h0000,1, 1,0,0,1));
    tv.push_back(mk(1,0,16'h0000,1, 1,0,0,0));
    // 00C0 with stalls
    tv.push_back(mk(1,1,16'h00C0,0, 1,0,0,0));
    tv.push_back(mk(1,0,16'h0000,0, 0,1,6,0));
    tv.push_back(mk(1,0,16'h0000,0, 0,1,6,0));
    tv.push_back(mk(1,0,16'h0000,0, 0,1,6,0));
    tv.push_back(mk(0,0,16'h0000,1, 0,0,0,0));
    tv.push_back(mk(0,0,16'h0000,1, 0,0,0,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,6,0));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,7,0));
    tv.push_back(mk(1,0,16'h0000,1, 1,0,0,1));
    // 0003 with ignored load, back-to-back load on done
    tv.push_back(mk(1,1,16'h0003,1, 1,0,0,0));
    tv.push_back(mk(1,1,16'hFFFF,1, 0,1,0,0));
    tv.push_back(mk(1,1,16'hFFFF,1, 0,1,1,0));
    tv.push_back(mk(1,1,16'h8000,1, 1,0,0,1));
    tv.push_back(mk(1,0,16'h0000,1, 0,1,15,0));
    tv.push_back(mk(1,0,16'h0000,0, 1,0,0,1));
    tv.push_back(mk(1,0,16'h0000,0, 1,0,0,0));

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      En = tv[i].en; load = tv[i].ld; D = tv[i].d; accept = tv[i].acc;
      #1;
      chk($sformatf("tv%0d.ready", i), ready, tv[i].rdy);
      chk($sformatf("tv%0d.valid", i), valid, tv[i].vld);
      chk($sformatf("tv%0d.W", i), W, tv[i].w);
      chk($sformatf("tv%0d.done", i), done, tv[i].dn);
      @(negedge clk);
    end

    // reset mid-scan of FFFF after two accepts
    En = 1; accept = 1; load = 1; D = 16'hFFFF;
    @(negedge clk);
    load = 0; D = '0;
    @(negedge clk);
    chk("mid.W1", W, 1);
    @(negedge clk);
    chk("mid.W2", W, 2);
    resetn = 1'b0;
    #1;
    chk("mid.valid", valid, 0);
    chk("mid.ready", ready, 1);
    chk("mid.done", done, 0);
`ifdef ENC_COUNT_EN
    chk("mid.cnt", cnt, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post.done", done, 0);
      chk("post.valid", valid, 0);
      @(negedge clk);
    end

`ifdef ENC_COUNT_EN
    // counter drain from full
    load = 1; D = 16'hFFFF; accept = 1; En = 1;
    @(negedge clk);
    load = 0;
    for (int i = 16; i >= 1; i--) begin
      #1;
      chk("cnt.drain", cnt, i);
      @(negedge clk);
    end
    #1;
    chk("cnt.zero", cnt, 0);
    chk("cnt.done", done, 1);
    @(negedge clk);
`endif

    // randomized run against model
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
    for (int c = 0; c < 600; c++) begin
      En     = ($urandom_range(0, 4) != 0);
      accept = ($urandom_range(0, 2) != 0);
      load   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: D = '0;
        1: D = 16'd1 << $urandom_range(0, 15);
        default: D = 16'($urandom);
      endcase
      #1;
      m_cycle("rnd");
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
